instr_encoder: RTL and testbench

//  Inverse of the core's immediate decode: packs {format, opcode, funct, regs, 32-bit immediate} into
//  RV32I instruction words. Expands LI pseudo-op to ADDI or LUI+ADDI. Registered valid/ready

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/imm_pack.sv | 48 ++++
 rtl/instr_encoder.sv | 155 +++++++++++++++
 tb/tb_instr_encoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, immediate format enum and small encode helpers
// used by the instruction encoder and its bit-scatter sub-module.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_J    = 3'd3,
        FMT_U    = 3'd4,
        FMT_LI   = 3'd5,
        FMT_BAD6 = 3'd6,
        FMT_BAD7 = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OUT   = 2'd1,
        ST_LI_HI = 2'd2,
        ST_LI_LO = 2'd3
    } enc_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [2:0] F3_ADDI    = 3'b000;

    // True when v[31:msb] are all copies of the same bit, i.e. v is a sign-extended msb+1 bit value.
    function automatic logic sext_fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] t;
        t = 32'($signed(v) >>> msb);
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] hi);
        return {hi, rd, OPC_LUI};
    endfunction

    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, F3_ADDI, rd, OPC_OP_IMM};
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational bit-scatter of a sign-extended immediate and register fields into an
// I/S/B/J/U instruction word, plus a flag for immediates the field cannot represent.
module imm_pack
    import riscv_pkg::*;
(
    input  imm_fmt_e    fmt_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    output logic [31:0] instr_o,
    output logic        range_err_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        instr_o     = '0;
        range_err_o = 1'b0;
        case (fmt_i)
            FMT_I: begin
                instr_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i} | {funct7_i, 25'd0};
                range_err_o = !sext_fits(imm_i, 11);
            end
            FMT_S: begin
                instr_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_err_o = !sext_fits(imm_i, 11);
            end
            FMT_B: begin
                instr_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
                range_err_o = !sext_fits(imm_i, 12) || imm_i[0];
            end
            FMT_J: begin
                instr_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_err_o = !sext_fits(imm_i, 20) || imm_i[0];
            end
            FMT_U: begin
                instr_o     = {imm_i[31:12], rd_i, opcode_i};
                range_err_o = (imm_i[11:0] != 12'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI expansion (ADDI or LUI+ADDI) and registered valid/ready streams.
// Optional immediate range rejection is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int SKIP_ZERO_LO = 1,
    parameter int FMT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FMT_W-1:0] req_fmt,
    input  logic [6:0]       req_opcode,
    input  logic [2:0]       req_funct3,
    input  logic [6:0]       req_funct7,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [31:0]      req_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             err
);

    localparam bit SKIP_LO = (SKIP_ZERO_LO != 0);

    enc_state_e  state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;
    logic        err_q, err_d;
    logic [4:0]  li_rd_q, li_rd_d;
    logic [11:0] li_lo_q, li_lo_d;

    imm_fmt_e    fmt;
    logic [31:0] pack_instr;
    logic        range_err;
    logic        illegal;
    logic        reject;
    logic        li_short;
    logic [19:0] li_hi;

    assign fmt = imm_fmt_e'(req_fmt);

    imm_pack u_imm_pack (
        .fmt_i       (fmt),
        .imm_i       (req_imm),
        .rd_i        (req_rd),
        .rs1_i       (req_rs1),
        .rs2_i       (req_rs2),
        .opcode_i    (req_opcode),
        .funct3_i    (req_funct3),
        .funct7_i    (req_funct7),
        .instr_o     (pack_instr),
        .range_err_o (range_err)
    );

    assign illegal = (fmt == FMT_BAD6) || (fmt == FMT_BAD7);

`ifdef IMM_RANGE_CHECK_EN
    assign reject = illegal || range_err;
`else
    logic unused_range_err;
    assign unused_range_err = range_err;
    assign reject           = illegal;
`endif

    // LUI upper part is rounded up when the low 12 bits will be sign-extended negative by ADDI.
    assign li_short = sext_fits(req_imm, 11);
    assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};

    assign req_ready = !out_valid_q || (out_ready && out_last_q);
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        li_rd_d     = li_rd_q;
        li_lo_d     = li_lo_q;

        if (req_valid && req_ready) begin
            // A new request may replace a word being consumed on the same edge.
            if (reject) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                err_d       = 1'b1;
                state_d     = ST_IDLE;
            end else if (fmt == FMT_LI) begin
                out_valid_d = 1'b1;
                if (li_short) begin
                    out_instr_d = enc_addi(req_rd, 5'd0, req_imm[11:0]);
                    out_last_d  = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    out_instr_d = enc_lui(req_rd, li_hi);
                    if (SKIP_LO && (req_imm[11:0] == 12'd0)) begin
                        out_last_d = 1'b1;
                        state_d    = ST_OUT;
                    end else begin
                        out_last_d = 1'b0;
                        li_rd_d    = req_rd;
                        li_lo_d    = req_imm[11:0];
                        state_d    = ST_LI_HI;
                    end
                end
            end else begin
                out_valid_d = 1'b1;
                out_instr_d = pack_instr;
                out_last_d  = 1'b1;
                state_d     = ST_OUT;
            end
        end else if (out_valid_q && out_ready) begin
            if (state_q == ST_LI_HI) begin
                out_instr_d = enc_addi(li_rd_q, li_rd_q, li_lo_q);
                out_last_d  = 1'b1;
                state_d     = ST_LI_LO;
            end else begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                state_d     = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            li_rd_q     <= '0;
            li_lo_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            li_rd_q     <= li_rd_d;
            li_lo_q     <= li_lo_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: queue-based reference model plus directed literal checks.
// Honours IMM_RANGE_CHECK_EN the same way as the design.
module tb_instr_encoder;

    localparam bit SKIP = 1'b1;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } word_t;

    logic        clk, reset;
    logic        req_valid, req_ready;
    logic [2:0]  req_fmt;
    logic [6:0]  req_opcode, req_funct7;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        out_valid, out_ready, out_last, err;
    logic [31:0] out_instr;

    int n_cmp = 0;
    int n_bad = 0;

    word_t exp_q[$];
    bit    err_exp  = 1'b0;
    bit    model_on = 1'b0;

    instr_encoder #(.SKIP_ZERO_LO(1), .FMT_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_last   (out_last),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic vec_t mk(input int fmt, input int op, input int f3, input int f7,
                                input int rd, input int rs1, input int rs2, input logic [31:0] imm);
        vec_t v;
        v.fmt = 3'(fmt); v.op = 7'(op); v.f3 = 3'(f3); v.f7 = 7'(f7);
        v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.imm = imm;
        return v;
    endfunction

    // Reference: arithmetic field placement straight from the RV32I formats.
    // Returns 1 when the request is rejected, otherwise queues the expected words.
    function automatic bit expand(input vec_t v);
        int          s;
        bit          rng;
        logic [31:0] w, imm, hi, lo, rd, rs1, rs2, f3, op;
        s   = $signed(v.imm);
        imm = v.imm;
        rd  = 32'(v.rd);  rs1 = 32'(v.rs1); rs2 = 32'(v.rs2);
        f3  = 32'(v.f3);  op  = 32'(v.op);
        rng = 1'b0;
        w   = '0;
        case (v.fmt)
            3'd0: begin
                rng = (s < -2048) || (s > 2047);
                w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
                if (v.f7 != 7'd0) w = w | (32'(v.f7) << 25);
            end
            3'd1: begin
                rng = (s < -2048) || (s > 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                  | ((imm & 32'h1F) << 7) | op;
            end
            3'd2: begin
                rng = (s < -4096) || (s > 4095) || (imm[0] == 1'b1);
                w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                  | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 32'h1) << 7) | op;
            end
            3'd3: begin
                rng = (s < -1048576) || (s > 1048575) || (imm[0] == 1'b1);
                w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            end
            3'd4: begin
                rng = (imm & 32'hFFF) != 32'd0;
                w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            end
            3'd5: begin
                lo = imm & 32'hFFF;
                if (s >= -2048 && s <= 2047) begin
                    exp_q.push_back('{instr: (lo << 20) | (rd << 7) | 32'h13, last: 1'b1});
                end else begin
                    hi = ((imm + 32'h800) >> 12) & 32'hFFFFF;
                    exp_q.push_back('{instr: (hi << 12) | (rd << 7) | 32'h37,
                                      last: (SKIP && lo == 32'd0)});
                    if (!(SKIP && lo == 32'd0))
                        exp_q.push_back('{instr: (lo << 20) | (rd << 15) | (rd << 7) | 32'h13,
                                          last: 1'b1});
                end
                return 1'b0;
            end
            default: return 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        if (rng) return 1'b1;
`else
        rng = 1'b0;
`endif
        exp_q.push_back('{instr: w, last: 1'b1});
        return rng;
    endfunction

    // Compare process: checks every output each cycle, then advances the model over the next edge.
    always @(negedge clk) begin
        bit   exp_ready;
        vec_t cv;
        exp_ready = (exp_q.size() == 0) || (out_ready && exp_q[0].last);
        if (model_on) begin
            check("m_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("m_out_instr", out_instr, exp_q[0].instr);
                check("m_out_last", 32'(out_last), 32'(exp_q[0].last));
            end
            check("m_err", 32'(err), 32'(err_exp));
            check("m_req_ready", 32'(req_ready), 32'(exp_ready));
        end
        if (reset) begin
            exp_q.delete();
            err_exp  = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            err_exp = 1'b0;
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (req_valid && exp_ready) begin
                cv.fmt = req_fmt; cv.op = req_opcode; cv.f3 = req_funct3; cv.f7 = req_funct7;
                cv.rd = req_rd; cv.rs1 = req_rs1; cv.rs2 = req_rs2; cv.imm = req_imm;
                err_exp = expand(cv);
            end
        end
    end

    task automatic set_req(input vec_t v);
        req_fmt = v.fmt; req_opcode = v.op; req_funct3 = v.f3; req_funct7 = v.f7;
        req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    endtask

    // Presents v until accepted; leaves req_valid high just after the accepting edge.
    task automatic drive_one(input vec_t v, input bit rnd);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        set_req(v);
        req_valid = 1'b1;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (!done) check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic send(input vec_t v);
        drive_one(v, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [31:0] instr, input bit last);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_instr"}, out_instr, instr);
        check({name, "_last"}, 32'(out_last), 32'(last));
    endtask

    vec_t burst[10];

    initial begin
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b1;
        set_req(mk(0, 0, 0, 0, 0, 0, 0, 32'd0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        send(mk(0, 'h13, 0, 0, 1, 0, 0, 32'd5));
        check_lit("t1_addi", 32'h00500093, 1'b1);

        send(mk(5, 0, 0, 0, 5, 0, 0, 32'h12345FFF));
        check_lit("t2_lui", 32'h123462B7, 1'b0);
        check_lit("t2_addi", 32'hFFF28293, 1'b1);
        send(mk(5, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF));
        check_lit("t2_li_m1", 32'hFFF00093, 1'b1);

        send(mk(2, 'h63, 0, 0, 0, 1, 2, 32'hFFFFFFFC));
        check_lit("t3_beq", 32'hFE208EE3, 1'b1);
        repeat (2) @(posedge clk);

        #1 out_ready = 1'b0;
        send(mk(5, 0, 0, 0, 5, 0, 0, 32'h12345FFF));
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_lui", out_instr, 32'h123462B7);
            check("t4_ready_lo", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("t4_lui_fire", out_instr, 32'h123462B7);
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_addi", out_instr, 32'hFFF28293);
            check("t4_ready_lo2", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        check("t4_ready_hi", 32'(req_ready), 32'd1);

        send(mk(0, 'h13, 0, 0, 1, 0, 0, 32'd2048));
`ifdef IMM_RANGE_CHECK_EN
        @(negedge clk);
        check("t5_err", 32'(err), 32'd1);
        check("t5_no_valid", 32'(out_valid), 32'd0);
`else
        check_lit("t5_wrap", 32'h80000093, 1'b1);
`endif

        burst[0] = mk(1, 'h23, 2, 0, 0, 2, 3, 32'hFFFFFFF8);
        burst[1] = mk(3, 'h6F, 0, 0, 1, 0, 0, 32'd2048);
        burst[2] = mk(4, 'h37, 0, 0, 3, 0, 0, 32'hABCDE000);
        burst[3] = mk(0, 'h13, 5, 'h20, 4, 4, 0, 32'd3);
        burst[4] = mk(5, 0, 0, 0, 6, 0, 0, 32'd100);
        burst[5] = mk(5, 0, 0, 0, 7, 0, 0, 32'h7FFFF800);
        burst[6] = mk(5, 0, 0, 0, 8, 0, 0, 32'h00005000);
        burst[7] = mk(6, 'h13, 0, 0, 1, 1, 1, 32'd1);
        burst[8] = mk(2, 'h63, 1, 0, 0, 3, 4, 32'd4094);
        burst[9] = mk(5, 0, 0, 0, 0, 0, 0, 32'h80000000);
        for (int i = 0; i < 10; i++) drive_one(burst[i], 1'b0);
        for (int i = 0; i < 10; i++) drive_one(burst[i], 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("burst_drained", 32'(out_valid), 32'd0);

        #1 out_ready = 1'b0;
        send(mk(5, 0, 0, 0, 5, 0, 0, 32'h12345FFF));
        @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd1);

        send(mk(7, 'h13, 0, 0, 1, 0, 0, 32'd1));
        @(negedge clk);
        check("t6_bad_err", 32'(err), 32'd1);
        check("t6_bad_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t6_err_pulse", 32'(err), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
